// File: rtl/lcd_text_feeder.sv
// Feeds the LCD write controller: runs the HD44780 init sequence, then turns bytes
// queued in a small character FIFO into one-cycle write commands with cursor tracking.
module lcd_text_feeder #(
  parameter int AW   = 4,
  parameter int COLS = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CHAR_VALID,
  input  logic [7:0] CHAR_DATA,
  output logic       CHAR_READY,
  input  logic       LCD_STATUS,
  output logic       LCD_WRITE,
  output logic [8:0] LCD_WRDATA,
  output logic       INIT_DONE
);

  localparam int DEPTH = 1 << AW;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_GUARD = 3'd3,
    S_WAITB = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       init_idx_q, init_idx_d;
  logic             init_done_q, init_done_d;
  logic             write_q, write_d;
  logic [8:0]       wrdata_q, wrdata_d;
  logic             row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             wrap_q, wrap_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]       fifo_mem_q [DEPTH];

  logic             full_s, empty_s, push_s, pop_s;
  logic [7:0]       head_s;

  function automatic logic [8:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = 9'h038;
      3'd1:    init_cmd = 9'h00C;
      3'd2:    init_cmd = 9'h001;
      3'd3:    init_cmd = 9'h006;
      default: init_cmd = 9'h000;
    endcase
  endfunction

  function automatic logic [8:0] row_addr(input logic row);
    row_addr = row ? 9'h0C0 : 9'h080;
  endfunction

  // Full when the pointers match except for the extra wrap bit.
  assign full_s     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign empty_s    = (wr_ptr_q == rd_ptr_q);
  assign push_s     = CHAR_VALID & ~full_s;
  assign head_s     = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign CHAR_READY = ~full_s;
  assign LCD_WRITE  = write_q;
  assign LCD_WRDATA = wrdata_q;
  assign INIT_DONE  = init_done_q;

  // Next-state, command selection and cursor update.
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    wrdata_d    = wrdata_q;
    row_d       = row_q;
    col_d       = col_q;
    wrap_d      = wrap_q;
    pop_s       = 1'b0;
    case (state_q)
      S_INIT: begin
        if (!LCD_STATUS) begin
          wrdata_d   = init_cmd(init_idx_q);
          init_idx_d = init_idx_q + 3'd1;
          state_d    = S_ISSUE;
        end else begin
          state_d = S_INIT;
        end
      end
      S_IDLE: begin
        if (!LCD_STATUS && wrap_q) begin
          wrdata_d = row_addr(row_q);
          wrap_d   = 1'b0;
          state_d  = S_ISSUE;
        end else if (!LCD_STATUS && !empty_s) begin
          pop_s   = 1'b1;
          state_d = S_ISSUE;
          case (head_s)
            8'h0A: begin
              row_d    = ~row_q;
              col_d    = {COL_W{1'b0}};
              wrdata_d = row_addr(~row_q);
            end
            8'h0C: begin
              row_d    = 1'b0;
              col_d    = {COL_W{1'b0}};
              wrap_d   = 1'b0;
              wrdata_d = 9'h001;
            end
            default: begin
              wrdata_d = {1'b1, head_s};
              if (col_q == COL_W'(COLS - 1)) begin
                col_d  = {COL_W{1'b0}};
                row_d  = ~row_q;
                wrap_d = 1'b1;
              end else begin
                col_d = col_q + COL_W'(1);
              end
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_GUARD;
      // Busy flag lags the strobe by a cycle, so it is not trusted here.
      S_GUARD: state_d = S_WAITB;
      S_WAITB: begin
        if (!LCD_STATUS) begin
          if (init_idx_q == 3'd4) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_INIT;
          end
        end else begin
          state_d = S_WAITB;
        end
      end
      default: state_d = S_INIT;
    endcase
    write_d  = (state_d == S_ISSUE);
    wr_ptr_d = push_s ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  end

  // Control state, cursor and FIFO pointers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_INIT;
      init_idx_q  <= 3'd0;
      init_done_q <= 1'b0;
      write_q     <= 1'b0;
      wrdata_q    <= 9'h000;
      row_q       <= 1'b0;
      col_q       <= {COL_W{1'b0}};
      wrap_q      <= 1'b0;
      wr_ptr_q    <= {(AW+1){1'b0}};
      rd_ptr_q    <= {(AW+1){1'b0}};
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      write_q     <= write_d;
      wrdata_q    <= wrdata_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wrap_q      <= wrap_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= CHAR_DATA;
    end
  end

endmodule
